// File: rtl/fwd_hazard_unit_pkg.sv
// Pipeline-wide widths and the producer tag tracked by the forwarding/hazard unit.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              is_load;
        logic [REG_AW-1:0] dest;
    } fwd_tag_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage issue/operand bus and the EX-side forwarding results of the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = 16
);

    logic                                  flush;
    logic                                  issue_valid;
    logic                                  issue_wen;
    logic                                  issue_is_load;
    logic [pipe_pkg::REG_AW-1:0]           issue_dest;
    logic [NUM_SRC-1:0]                    src_used;
    logic [NUM_SRC*pipe_pkg::REG_AW-1:0]   src_addr;
    logic [DEPTH*pipe_pkg::DATA_W-1:0]     stage_result;
    logic [NUM_SRC-1:0]                    fwd_hit;
    logic [NUM_SRC*pipe_pkg::DATA_W-1:0]   fwd_data;
    logic                                  stall;
    logic [CNT_W-1:0]                      stall_cnt;

    // Pipeline control side.
    modport master (
        output flush, issue_valid, issue_wen, issue_is_load, issue_dest,
        output src_used, src_addr, stage_result,
        input  fwd_hit, fwd_data, stall, stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  flush, issue_valid, issue_wen, issue_is_load, issue_dest,
        input  src_used, src_addr, stage_result,
        output fwd_hit, fwd_data, stall, stall_cnt
    );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// One operand's tag compare against every tracked producer; the youngest match wins.
module fwd_match_prio
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    localparam int unsigned SLOT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  fwd_tag_t [DEPTH-1:0] tags_i,
    input  logic                 src_used_i,
    input  logic [REG_AW-1:0]    src_addr_i,
    output logic                 hit_c_o,
    output logic [SLOT_W-1:0]    slot_c_o,
    output logic                 not_ready_c_o
);

    // Scan from youngest; the first match locks out all older slots.
    always_comb begin
        hit_c_o       = 1'b0;
        slot_c_o      = '0;
        not_ready_c_o = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit_c_o && src_used_i && (src_addr_i != REG_ZERO) &&
                tags_i[k].valid && tags_i[k].wen && (tags_i[k].dest == src_addr_i)) begin
                hit_c_o       = 1'b1;
                slot_c_o      = SLOT_W'(k);
                not_ready_c_o = tags_i[k].is_load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit at the ID->EX boundary of the 5-stage pipeline.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    fwd_hazard_unit_if.slave  bus
);

    localparam int unsigned SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fwd_tag_t [DEPTH-1:0]      tags_q, tags_d;
    logic [DATA_W-1:0]         result [DEPTH];
    logic [NUM_SRC-1:0]        hit_c;
    logic [NUM_SRC-1:0]        not_ready_c;
    logic [SLOT_W-1:0]         slot_c [NUM_SRC];
    logic                      stall_c;
    logic [NUM_SRC-1:0]        fwd_hit_q, fwd_hit_d;
    logic [NUM_SRC*DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

    for (genvar k = 0; k < DEPTH; k++) begin : g_result
        assign result[k] = bus.stage_result[k*DATA_W +: DATA_W];
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_match_prio #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .tags_i        (tags_q),
            .src_used_i    (bus.src_used[i]),
            .src_addr_i    (bus.src_addr[i*REG_AW +: REG_AW]),
            .hit_c_o       (hit_c[i]),
            .slot_c_o      (slot_c[i]),
            .not_ready_c_o (not_ready_c[i])
        );
    end

    // Only a winning producer that is still too young to have data can stall.
    assign stall_c = |not_ready_c;

    // Tag shift: a stalled issue enters as a bubble; flush empties the pipe.
    always_comb begin
        tags_d = tags_q;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            tags_d[k] = tags_q[k-1];
        end
        tags_d[0].valid   = bus.issue_valid && !stall_c;
        tags_d[0].wen     = bus.issue_wen;
        tags_d[0].is_load = bus.issue_is_load;
        tags_d[0].dest    = bus.issue_dest;
        if (bus.flush) begin
            tags_d = '0;
        end
    end

    // Forwarded operands for EX; a stall sends a zeroed bubble instead.
    always_comb begin
        fwd_hit_d  = '0;
        fwd_data_d = '0;
        if (!stall_c) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                fwd_hit_d[i] = hit_c[i];
                if (hit_c[i]) begin
                    fwd_data_d[i*DATA_W +: DATA_W] = result[slot_c[i]];
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tags_q      <= '0;
            fwd_hit_q   <= '0;
            fwd_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            tags_q      <= tags_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_hit   = fwd_hit_q;
    assign bus.fwd_data  = fwd_data_q;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
